fir_filter_core: RTL
====================

# fir_filter_core

Four-tap FIR compute engine. It sits directly downstream of the AHB-Lite slave register file and consumes its `sample_data`, `data_ready`, `new_coefficient_set` and `fir_coefficient` outputs. It returns `processed`, `clear_new_coefficient`, `coefficient_num`, `modwait`, `fir_out` and `err` to that slave. Coefficient reloads and sample processing are sequenced by a single Moore FSM using one shared multiply-accumulate datapath.

## Interface
- FRAC_BITS, 15, fractional bits of coefficient format (Q1.15); result = accumulator >> FRAC_BITS
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- sample_data  in  16  unsigned sample from slave sample register
- data_ready  in  1  new sample pending (level, cleared by slave one cycle after `processed`)
- new_coefficient_set  in  1  coefficient reload requested (level)
- fir_coefficient  in  16  coefficient selected by `coefficient_num` (combinational from slave)
- coefficient_num  out  2  coefficient index being read
- clear_new_coefficient  out  1  one-cycle pulse, ends reload request
- processed  out  1  one-cycle pulse, sample consumed
- modwait  out  1  engine busy
- fir_out  out  16  last filter result (registered)
- err  out  1  last result saturated

## Operation
- States: IDLE, LOAD0..LOAD3, CLR, SHIFT, MAC0..MAC3, STORE.
- IDLE priority: `new_coefficient_set`=1 -> LOAD0. Otherwise `data_ready`=1 -> SHIFT. Otherwise stay.
- LOADk: `coefficient_num`=k; `coef[k]` <= `fir_coefficient` at end of cycle. LOAD3 -> CLR.
- CLR: `clear_new_coefficient`=1; -> IDLE.
- SHIFT: `processed`=1. Window shifts, with s3<=s2, s2<=s1, s1<=s0, s0<=`sample_data`. Accumulator <= 0. -> MAC0.
- MACk: acc <= acc + s_k*coef[k]. The product is 32-bit unsigned; acc is 34-bit unsigned. MAC3 -> STORE.
- STORE: if acc[33:31] != 0, `fir_out` <= 16'hFFFF and `err` <= 1. Else `fir_out` <= acc[30:15] (truncation, no rounding) and `err` <= 0. -> IDLE.
- `modwait` = (state != IDLE). `coefficient_num` = 0 outside LOAD states.
- Requests arriving while busy are not lost. Both inputs are levels and are serviced on the next IDLE.
- Reset: state IDLE; window, coefficients, acc, `fir_out` all 0; `err`, `processed`, `clear_new_coefficient`, `modwait` 0; `coefficient_num` 0.

## Timing
- All outputs are Moore/registered. There are no combinational paths from inputs to outputs.
- Sample path: `data_ready` is high in IDLE at cycle 0. Then SHIFT is cycle 1 (`processed`=1), MAC0–MAC3 are cycles 2–5, and STORE is cycle 6. New `fir_out`/`err` are visible and `modwait`=0 from cycle 7.
- `data_ready` is still high during SHIFT. The FSM has left IDLE, so no double consume occurs.
- Reload path: LOAD0–LOAD3 are cycles 1–4. CLR is cycle 5. The slave drops `new_coefficient_set` at cycle 6 and the FSM returns to IDLE at cycle 6. IDLE must not re-enter LOAD0 on a stale request. The FSM therefore takes one idle cycle after CLR (CLR -> IDLE, and IDLE sees the cleared level because the slave clears it combinationally-next-edge).
- Reset mid-operation aborts immediately. No `processed` or `clear_new_coefficient` pulse is emitted.

## Structure
- Shared package `fir_pkg` holds:
  - the state enum
  - NUM_TAPS=4
  - SAMPLE_W=16, COEF_W=16, PROD_W=32, ACC_W=34
  - the saturation constant 16'hFFFF
- Sub-module `fir_mac_unit` covers the 4-entry sample window, the coefficient bank, the multiplier, the accumulator and the saturation logic. It is driven by shift/load/mac/store strobes and a tap index from the FSM in `fir_filter_core`.

## Test plan
- Reload: coefficients 0x1000/0x2000/0x3000/0x4000 with `new_coefficient_set`=1. Required: `coefficient_num` = 0,1,2,3 in cycles 1–4; `clear_new_coefficient` pulses in cycle 5; `modwait`=1 in cycles 1–5.
- Unity filter: all coefficients 0x8000; samples 100, 200, 300, 400. Required `fir_out` = 100, 300, 600, 1000; `err`=0; each `processed` pulse is exactly 1 cycle; result appears 7 cycles after `data_ready`.
- Saturation: all coefficients 0xFFFF; four samples 0xFFFF. Required: `fir_out`=0xFFFF, `err`=1. Then reload all coefficients 0 and send sample 5. Required: `fir_out`=0, `err`=0.
- Priority: `data_ready` and `new_coefficient_set` rise in the same cycle. Required: LOAD sequence runs first, then SHIFT, with exactly one `processed` pulse.
- Busy arrival: assert `new_coefficient_set` during MAC1. Required: reload starts only after STORE -> IDLE, and the current `fir_out` is unaffected.
- Reset during MAC2. Required: all outputs 0 next cycle. With coefficients now 0, the next sample 0x1234 gives `fir_out`=0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and constants for the four-tap FIR engine.
// Widths, tap count, saturation value and FSM state encoding.
package fir_pkg;

    localparam int NUM_TAPS      = 4;
    localparam int TAP_W         = 2;
    localparam int SAMPLE_W      = 16;
    localparam int COEF_W        = 16;
    localparam int PROD_W        = 32;
    localparam int ACC_W         = 34;
    localparam int DEF_FRAC_BITS = 15;

    localparam logic [SAMPLE_W-1:0] SAT_VAL = 16'hFFFF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD0,
        S_LOAD1,
        S_LOAD2,
        S_LOAD3,
        S_CLR,
        S_SHIFT,
        S_MAC0,
        S_MAC1,
        S_MAC2,
        S_MAC3,
        S_STORE
    } fir_state_t;

endpackage

// File: rtl/fir_mac_unit.sv
// Sample window, coefficient bank and shared multiply-accumulate.
// Strobed by the sequencer; result saturates to all-ones on overflow.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                i_shift,
    input  logic                i_load,
    input  logic                i_mac,
    input  logic                i_store,
    input  logic [TAP_W-1:0]    i_tap,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic [COEF_W-1:0]   i_coef,
    output logic [SAMPLE_W-1:0] o_fir_out,
    output logic                o_err
);

    logic [SAMPLE_W-1:0] r_win  [NUM_TAPS];
    logic [COEF_W-1:0]   r_coef [NUM_TAPS];
    logic [ACC_W-1:0]    r_acc;
    logic [SAMPLE_W-1:0] r_fir_out;
    logic                r_err;

    logic [PROD_W-1:0]   w_prod;
    logic                w_ovf;
    logic [SAMPLE_W-1:0] w_trunc;

    assign w_prod  = PROD_W'(r_win[i_tap]) * PROD_W'(r_coef[i_tap]);
    assign w_ovf   = |r_acc[ACC_W-1:FRAC_BITS+SAMPLE_W];
    assign w_trunc = r_acc[FRAC_BITS +: SAMPLE_W];

    assign o_fir_out = r_fir_out;
    assign o_err     = r_err;

    // Sample window: newest sample enters tap 0, oldest falls off tap 3
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_TAPS; i++) r_win[i] <= '0;
        end else if (i_shift) begin
            r_win[0] <= i_sample;
            for (int i = 1; i < NUM_TAPS; i++) r_win[i] <= r_win[i-1];
        end
    end

    // Coefficient bank: one entry written per load strobe
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_TAPS; i++) r_coef[i] <= '0;
        end else if (i_load) begin
            r_coef[i_tap] <= i_coef;
        end
    end

    // Accumulator: cleared with the window shift, then one product per tap
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_acc <= '0;
        end else if (i_shift) begin
            r_acc <= '0;
        end else if (i_mac) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

    // Result register: truncated Q1.15 product sum, or saturate with error
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_fir_out <= '0;
            r_err     <= 1'b0;
        end else if (i_store) begin
            if (w_ovf) begin
                r_fir_out <= SAT_VAL;
                r_err     <= 1'b1;
            end else begin
                r_fir_out <= w_trunc;
                r_err     <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fir_filter_core.sv
// Four-tap FIR engine: Moore sequencer over a shared MAC datapath.
// Coefficient reloads take priority over pending samples in IDLE.
module fir_filter_core
    import fir_pkg::*;
#(
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                data_ready,
    input  logic                new_coefficient_set,
    input  logic [COEF_W-1:0]   fir_coefficient,
    output logic [TAP_W-1:0]    coefficient_num,
    output logic                clear_new_coefficient,
    output logic                processed,
    output logic                modwait,
    output logic [SAMPLE_W-1:0] fir_out,
    output logic                err
);

    fir_state_t r_state;
    fir_state_t w_next;

    logic             w_shift;
    logic             w_load;
    logic             w_mac;
    logic             w_store;
    logic [TAP_W-1:0] w_tap;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and Moore outputs decoded from the current state
    always_comb begin
        w_next                = r_state;
        w_shift               = 1'b0;
        w_load                = 1'b0;
        w_mac                 = 1'b0;
        w_store               = 1'b0;
        w_tap                 = '0;
        coefficient_num       = '0;
        clear_new_coefficient = 1'b0;
        processed             = 1'b0;
        modwait               = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                if (new_coefficient_set) w_next = S_LOAD0;
                else if (data_ready)     w_next = S_SHIFT;
            end
            S_LOAD0: begin
                w_load = 1'b1;
                w_tap  = 2'd0;
                w_next = S_LOAD1;
            end
            S_LOAD1: begin
                w_load = 1'b1;
                w_tap  = 2'd1;
                w_next = S_LOAD2;
            end
            S_LOAD2: begin
                w_load = 1'b1;
                w_tap  = 2'd2;
                w_next = S_LOAD3;
            end
            S_LOAD3: begin
                w_load = 1'b1;
                w_tap  = 2'd3;
                w_next = S_CLR;
            end
            S_CLR: begin
                clear_new_coefficient = 1'b1;
                w_next                = S_IDLE;
            end
            S_SHIFT: begin
                processed = 1'b1;
                w_shift   = 1'b1;
                w_next    = S_MAC0;
            end
            S_MAC0: begin
                w_mac  = 1'b1;
                w_tap  = 2'd0;
                w_next = S_MAC1;
            end
            S_MAC1: begin
                w_mac  = 1'b1;
                w_tap  = 2'd1;
                w_next = S_MAC2;
            end
            S_MAC2: begin
                w_mac  = 1'b1;
                w_tap  = 2'd2;
                w_next = S_MAC3;
            end
            S_MAC3: begin
                w_mac  = 1'b1;
                w_tap  = 2'd3;
                w_next = S_STORE;
            end
            S_STORE: begin
                w_store = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_load) coefficient_num = w_tap;
    end

    fir_mac_unit #(
        .FRAC_BITS (FRAC_BITS)
    ) u_mac (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_shift   (w_shift),
        .i_load    (w_load),
        .i_mac     (w_mac),
        .i_store   (w_store),
        .i_tap     (w_tap),
        .i_sample  (sample_data),
        .i_coef    (fir_coefficient),
        .o_fir_out (fir_out),
        .o_err     (err)
    );

endmodule
